slc3_control_fsm: RTL

Parametrised instruction sequencing and decode unit for the SLC-3 datapath, successor to the fixed-timing ISDU. Drives all load enables, bus gates, mux selects and SRAM strobes for fetch/decode/execute. Adds a configurable memory wait count, an optional memory-ready handshake, JSRR support and a compile-time PAUSE enable.

---
 rtl/slc3_pkg.sv | 84 ++++++++
 rtl/slc3_control_fsm_if.sv | 27 ++
 rtl/slc3_mem_timer.sv | 37 +++
 rtl/slc3_control_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 control unit.
package slc3_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned STATE_W = 5;
    localparam int unsigned WAIT_W  = 4;

    // Opcodes (IR[15:12])
    localparam logic [OPC_W-1:0] OP_BR    = 4'b0000;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OPC_W-1:0] OP_JSR   = 4'b0100;
    localparam logic [OPC_W-1:0] OP_AND   = 4'b0101;
    localparam logic [OPC_W-1:0] OP_LDR   = 4'b0110;
    localparam logic [OPC_W-1:0] OP_STR   = 4'b0111;
    localparam logic [OPC_W-1:0] OP_NOT   = 4'b1001;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'b1100;
    localparam logic [OPC_W-1:0] OP_PAUSE = 4'b1101;

    // ALU function select
    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // PC source select
    localparam logic [1:0] PCMUX_INC  = 2'b00;
    localparam logic [1:0] PCMUX_BUS  = 2'b01;
    localparam logic [1:0] PCMUX_ADDR = 2'b10;

    // Address adder offset select
    localparam logic [1:0] A2_ZERO  = 2'b00;
    localparam logic [1:0] A2_OFF6  = 2'b01;
    localparam logic [1:0] A2_OFF9  = 2'b10;
    localparam logic [1:0] A2_OFF11 = 2'b11;

    typedef enum logic [STATE_W-1:0] {
        HALTED   = 5'd0,
        F_MAR    = 5'd1,
        F_MEM    = 5'd2,
        F_IR     = 5'd3,
        DECODE   = 5'd4,
        EX_ADD   = 5'd5,
        EX_AND   = 5'd6,
        EX_NOT   = 5'd7,
        BR       = 5'd8,
        BR_TAKEN = 5'd9,
        JMP      = 5'd10,
        JSR_LINK = 5'd11,
        JSR_PC   = 5'd12,
        LDR_ADDR = 5'd13,
        LDR_MEM  = 5'd14,
        LDR_WB   = 5'd15,
        STR_ADDR = 5'd16,
        STR_MDR  = 5'd17,
        STR_MEM  = 5'd18,
        PAUSE1   = 5'd19,
        PAUSE2   = 5'd20
    } state_t;

    typedef struct packed {
        logic       LD_MAR;
        logic       LD_MDR;
        logic       LD_IR;
        logic       LD_BEN;
        logic       LD_CC;
        logic       LD_REG;
        logic       LD_PC;
        logic       LD_LED;
        logic       GatePC;
        logic       GateMDR;
        logic       GateALU;
        logic       GateMARMUX;
        logic [1:0] PCMUX;
        logic       DRMUX;
        logic       SR1MUX;
        logic       SR2MUX;
        logic       ADDR1MUX;
        logic [1:0] ADDR2MUX;
        logic [1:0] ALUK;
        logic       Mem_OE;
        logic       Mem_WE;
    } slc3_ctrl_t;

endpackage

// File: rtl/slc3_control_fsm_if.sv
// Control-unit <-> datapath signal bundle.
interface slc3_control_fsm_if;
    import slc3_pkg::*;

    logic                 Run;
    logic                 Continue;
    logic [OPC_W-1:0]     Opcode;
    logic                 IR_5;
    logic                 IR_11;
    logic                 BEN;
    logic                 Mem_Ready;
    slc3_ctrl_t           Ctrl;
    logic [STATE_W-1:0]   State_dbg;

    // Control unit side
    modport master (
        input  Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
        output Ctrl, State_dbg
    );

    // Datapath / front-panel side
    modport slave (
        output Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
        input  Ctrl, State_dbg
    );

endinterface

// File: rtl/slc3_mem_timer.sv
// Memory access length tracker shared by all SRAM states.
// Counter mode: done on the MEM_WAIT-th cycle of an access.
// Ready mode: done in any cycle where Mem_Ready is high.
module slc3_mem_timer
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT  = 2,
    parameter bit          USE_READY = 1'b0
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic active,
    input  logic mem_ready,
    output logic done_c
);

    localparam logic [WAIT_W-1:0] LAST = WAIT_W'(MEM_WAIT - 1);

    logic [WAIT_W-1:0] count;

    // Count cycles of the current access; idle at zero between accesses
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (!active || done_c || USE_READY) begin
            count <= '0;
        end else begin
            count <= count + WAIT_W'(1);
        end
    end

    // Access completion
    always_comb begin
        done_c = USE_READY ? mem_ready : (count == LAST);
    end

endmodule

// File: rtl/slc3_control_fsm.sv
// SLC-3 instruction sequencing and decode unit.
// Ctrl is a Moore decode of the state (IR_5/IR_11 steer operand muxes,
// LD_MDR marks the completing cycle of a read).
module slc3_control_fsm
    import slc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT  = 2,
    parameter bit          USE_READY = 1'b0,
    parameter bit          PAUSE_EN  = 1'b1
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    slc3_control_fsm_if.master        bus
);

    state_t     state;
    state_t     next_state;
    slc3_ctrl_t ctrl;
    logic       mem_active;
    logic       mem_done;

    // Memory states share one access timer
    always_comb begin
        mem_active = (state == F_MEM) || (state == LDR_MEM) || (state == STR_MEM);
    end

    slc3_mem_timer #(
        .MEM_WAIT  (MEM_WAIT),
        .USE_READY (USE_READY)
    ) u_mem_timer (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .active    (mem_active),
        .mem_ready (bus.Mem_Ready),
        .done_c    (mem_done)
    );

    // State register; reset abandons any access in flight
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= HALTED;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control decode
    always_comb begin
        next_state = state;
        ctrl       = '0;

        case (state)
            HALTED: begin
                if (bus.Run) next_state = F_MAR;
            end

            F_MAR: begin
                ctrl.GatePC = 1'b1;
                ctrl.LD_MAR = 1'b1;
                ctrl.LD_PC  = 1'b1;
                ctrl.PCMUX  = PCMUX_INC;
                next_state  = F_MEM;
            end

            F_MEM: begin
                ctrl.Mem_OE = 1'b1;
                ctrl.LD_MDR = mem_done;
                if (mem_done) next_state = F_IR;
            end

            F_IR: begin
                ctrl.GateMDR = 1'b1;
                ctrl.LD_IR   = 1'b1;
                next_state   = DECODE;
            end

            DECODE: begin
                ctrl.LD_BEN = 1'b1;
                case (bus.Opcode)
                    OP_ADD:   next_state = EX_ADD;
                    OP_AND:   next_state = EX_AND;
                    OP_NOT:   next_state = EX_NOT;
                    OP_BR:    next_state = BR;
                    OP_JMP:   next_state = JMP;
                    OP_JSR:   next_state = JSR_LINK;
                    OP_LDR:   next_state = LDR_ADDR;
                    OP_STR:   next_state = STR_ADDR;
                    OP_PAUSE: next_state = PAUSE_EN ? PAUSE1 : F_MAR;
                    default:  next_state = F_MAR;
                endcase
            end

            EX_ADD: begin
                ctrl.SR1MUX  = 1'b1;
                ctrl.SR2MUX  = bus.IR_5;
                ctrl.ALUK    = ALUK_ADD;
                ctrl.GateALU = 1'b1;
                ctrl.LD_REG  = 1'b1;
                ctrl.LD_CC   = 1'b1;
                next_state   = F_MAR;
            end

            EX_AND: begin
                ctrl.SR1MUX  = 1'b1;
                ctrl.SR2MUX  = bus.IR_5;
                ctrl.ALUK    = ALUK_AND;
                ctrl.GateALU = 1'b1;
                ctrl.LD_REG  = 1'b1;
                ctrl.LD_CC   = 1'b1;
                next_state   = F_MAR;
            end

            EX_NOT: begin
                ctrl.SR1MUX  = 1'b1;
                ctrl.ALUK    = ALUK_NOT;
                ctrl.GateALU = 1'b1;
                ctrl.LD_REG  = 1'b1;
                ctrl.LD_CC   = 1'b1;
                next_state   = F_MAR;
            end

            BR: begin
                next_state = bus.BEN ? BR_TAKEN : F_MAR;
            end

            BR_TAKEN: begin
                ctrl.ADDR2MUX = A2_OFF9;
                ctrl.PCMUX    = PCMUX_ADDR;
                ctrl.LD_PC    = 1'b1;
                next_state    = F_MAR;
            end

            JMP: begin
                ctrl.SR1MUX  = 1'b1;
                ctrl.ALUK    = ALUK_PASSA;
                ctrl.GateALU = 1'b1;
                ctrl.PCMUX   = PCMUX_BUS;
                ctrl.LD_PC   = 1'b1;
                next_state   = F_MAR;
            end

            // R7 <- PC; a JSRR through R7 therefore sees the new link value
            JSR_LINK: begin
                ctrl.GatePC = 1'b1;
                ctrl.DRMUX  = 1'b1;
                ctrl.LD_REG = 1'b1;
                next_state  = JSR_PC;
            end

            JSR_PC: begin
                ctrl.PCMUX = PCMUX_ADDR;
                ctrl.LD_PC = 1'b1;
                if (bus.IR_11) begin
                    ctrl.ADDR2MUX = A2_OFF11;
                end else begin
                    ctrl.ADDR1MUX = 1'b1;
                    ctrl.SR1MUX   = 1'b1;
                    ctrl.ADDR2MUX = A2_ZERO;
                end
                next_state = F_MAR;
            end

            LDR_ADDR, STR_ADDR: begin
                ctrl.SR1MUX     = 1'b1;
                ctrl.ADDR1MUX   = 1'b1;
                ctrl.ADDR2MUX   = A2_OFF6;
                ctrl.GateMARMUX = 1'b1;
                ctrl.LD_MAR     = 1'b1;
                next_state      = (state == LDR_ADDR) ? LDR_MEM : STR_MDR;
            end

            LDR_MEM: begin
                ctrl.Mem_OE = 1'b1;
                ctrl.LD_MDR = mem_done;
                if (mem_done) next_state = LDR_WB;
            end

            LDR_WB: begin
                ctrl.GateMDR = 1'b1;
                ctrl.LD_REG  = 1'b1;
                ctrl.LD_CC   = 1'b1;
                next_state   = F_MAR;
            end

            STR_MDR: begin
                ctrl.ALUK    = ALUK_PASSA;
                ctrl.GateALU = 1'b1;
                ctrl.LD_MDR  = 1'b1;
                next_state   = STR_MEM;
            end

            STR_MEM: begin
                ctrl.Mem_WE = 1'b1;
                if (mem_done) next_state = F_MAR;
            end

            PAUSE1: begin
                ctrl.LD_LED = 1'b1;
                if (bus.Continue) next_state = PAUSE2;
            end

            PAUSE2: begin
                if (!bus.Continue) next_state = F_MAR;
            end

            default: begin
                next_state = HALTED;
            end
        endcase
    end

    assign bus.Ctrl      = ctrl;
    assign bus.State_dbg = state;

endmodule
